// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin scheduler that shares one bit-serial
// pattern matcher among NREQ byte-wide requesters. Each granted byte is
// shifted MSB-first through a PAT_W-bit window compared against a
// programmable pattern; per-channel window/fill history is saved and
// restored so matches straddling byte boundaries on one channel are found.
//
// Optional feature macro: SEQ_ARB_STATS_EN (per-channel 16-bit saturating
// match counters, read combinationally via stat_sel_i/stat_data_o).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_i             per-channel request, held until granted
//   req_data_i        channel i byte at [8i+7:8i]
//   grant_o           one-hot one-cycle grant pulse
//   cfg_we_i          pattern write strobe (honoured in IDLE only)
//   cfg_pattern_i     new pattern
//   busy_o            high whenever the FSM is not IDLE
//   det_valid_o       one-cycle result strobe
//   det_chan_o        channel of the result
//   det_count_o       matches found within the byte (0..8)
//   stat_sel_i        statistics channel select
//   stat_data_o       statistics read data
module seq_detect_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PAT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [8*NREQ-1:0]     req_data_i,
  output logic [NREQ-1:0]       grant_o,
  input  logic                  cfg_we_i,
  input  logic [PAT_W-1:0]      cfg_pattern_i,
  output logic                  busy_o,
  output logic                  det_valid_o,
  output logic [$clog2(NREQ)-1:0] det_chan_o,
  output logic [3:0]            det_count_o,
  input  logic [$clog2(NREQ)-1:0] stat_sel_i,
  output logic [15:0]           stat_data_o
);

  localparam int unsigned CHW = $clog2(NREQ);
  localparam int unsigned FW  = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 det_valid_q, det_valid_d;
  logic [CHW-1:0]       det_chan_q, det_chan_d;
  logic [3:0]           det_count_q, det_count_d;
  logic [PAT_W-1:0]     pattern_q, pattern_d;
  logic [PAT_W-1:0]     win_q [NREQ];
  logic [PAT_W-1:0]     win_d [NREQ];
  logic [FW-1:0]        fill_q [NREQ];
  logic [FW-1:0]        fill_d [NREQ];
  logic [CHW-1:0]       last_q, last_d;
  logic [CHW-1:0]       chan_q, chan_d;
  logic [7:0]           byte_q, byte_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]     cur_win_q, cur_win_d;
  logic [FW-1:0]        cur_fill_q, cur_fill_d;
  logic [3:0]           acc_q, acc_d;

  logic                 pick_vld;
  logic [CHW-1:0]       pick_idx;
  logic                 shift_bit;
  logic [PAT_W-1:0]     win_nx;
  logic [FW-1:0]        fill_nx;
  logic                 hit;
  logic [3:0]           acc_nx;

`ifdef SEQ_ARB_STATS_EN
  logic [15:0]          stat_q [NREQ];
  logic [15:0]          stat_d [NREQ];
  logic [16:0]          stat_sum;
`endif

  // Round-robin pick: search from last_q+1 cyclically
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!pick_vld && req_i[CHW'((32'(last_q) + k) % NREQ)]) begin
        pick_vld = 1'b1;
        pick_idx = CHW'((32'(last_q) + k) % NREQ);
      end
    end
  end

  // Serial datapath for the bit currently being shifted
  always_comb begin
    shift_bit = byte_q[3'd7 - bit_cnt_q];
    win_nx    = {cur_win_q[PAT_W-2:0], shift_bit};
    fill_nx   = (cur_fill_q == FW'(PAT_W)) ? cur_fill_q : cur_fill_q + FW'(1);
    hit       = (fill_nx == FW'(PAT_W)) && (win_nx == pattern_q);
    acc_nx    = acc_q + 4'(hit);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    det_valid_d = 1'b0;
    det_chan_d  = det_chan_q;
    det_count_d = det_count_q;
    pattern_d   = pattern_q;
    win_d       = win_q;
    fill_d      = fill_q;
    last_d      = last_q;
    chan_d      = chan_q;
    byte_d      = byte_q;
    bit_cnt_d   = bit_cnt_q;
    cur_win_d   = cur_win_q;
    cur_fill_d  = cur_fill_q;
    acc_d       = acc_q;
`ifdef SEQ_ARB_STATS_EN
    stat_d      = stat_q;
    stat_sum    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          // Pattern change invalidates all history; grant waits a cycle
          pattern_d = cfg_pattern_i;
          for (int i = 0; i < int'(NREQ); i++) fill_d[i] = '0;
        end else if (pick_vld) begin
          grant_d    = NREQ'(1) << pick_idx;
          chan_d     = pick_idx;
          byte_d     = req_data_i[8*int'(pick_idx) +: 8];
          cur_win_d  = win_q[pick_idx];
          cur_fill_d = fill_q[pick_idx];
          bit_cnt_d  = '0;
          acc_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        cur_win_d  = win_nx;
        cur_fill_d = fill_nx;
        acc_d      = acc_nx;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // Last bit: save history and register the result
          win_d[chan_q]  = win_nx;
          fill_d[chan_q] = fill_nx;
          last_d         = chan_q;
          det_valid_d    = 1'b1;
          det_chan_d     = chan_q;
          det_count_d    = acc_nx;
          state_d        = REPORT;
`ifdef SEQ_ARB_STATS_EN
          stat_sum       = {1'b0, stat_q[chan_q]} + 17'(acc_nx);
          stat_d[chan_q] = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
`endif
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      det_valid_q <= 1'b0;
      det_chan_q  <= '0;
      det_count_q <= '0;
      pattern_q   <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        win_q[i]  <= '0;
        fill_q[i] <= '0;
      end
      last_q      <= CHW'(NREQ - 1);
      chan_q      <= '0;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      cur_win_q   <= '0;
      cur_fill_q  <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      det_valid_q <= det_valid_d;
      det_chan_q  <= det_chan_d;
      det_count_q <= det_count_d;
      pattern_q   <= pattern_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      last_q      <= last_d;
      chan_q      <= chan_d;
      byte_q      <= byte_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_win_q   <= cur_win_d;
      cur_fill_q  <= cur_fill_d;
      acc_q       <= acc_d;
    end
  end

`ifdef SEQ_ARB_STATS_EN
  // Statistics counters survive pattern writes; cleared by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  // Combinational statistics read
  always_comb begin
    stat_data_o = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (stat_sel_i == CHW'(i)) stat_data_o = stat_q[i];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel_i;
  assign stat_data_o     = 16'h0000;
`endif

  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign det_valid_o = det_valid_q;
  assign det_chan_o  = det_chan_q;
  assign det_count_o = det_count_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter (NREQ=4, PAT_W=8): directed
// transactions push their expected {channel, count} into a queue and a
// forked monitor pops and compares on every det_valid strobe.
module tb_seq_detect_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic        busy;
  logic        det_valid;
  logic [1:0]  det_chan;
  logic [3:0]  det_count;
  logic [1:0]  stat_sel;
  logic [15:0] stat_data;

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  seq_detect_arbiter #(.NREQ(4), .PAT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .req_data_i   (req_data),
    .grant_o      (grant),
    .cfg_we_i     (cfg_we),
    .cfg_pattern_i(cfg_pattern),
    .busy_o       (busy),
    .det_valid_o  (det_valid),
    .det_chan_o   (det_chan),
    .det_count_o  (det_count),
    .stat_sel_i   (stat_sel),
    .stat_data_o  (stat_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (det_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_det_valid", 32'(det_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("det_chan", 32'(det_chan), 32'(e.chan));
          check("det_count", 32'(det_count), 32'(e.cnt));
        end
      end
    end
  endtask

  task automatic wait_grant(input int ch);
    logic [3:0] want;
    want = 4'b0001 << ch;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (grant != 4'b0000) break;
    end
    check("grant", 32'(grant), 32'(want));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy && !det_valid) break;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic write_pattern(input logic [7:0] p);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One byte on one channel; cfg_mid pulses a pattern write during SHIFT
  task automatic send(input int ch, input logic [7:0] b, input int cnt, input bit cfg_mid);
    @(negedge clk);
    req[ch] = 1'b1;
    req_data[ch*8 +: 8] = b;
    exp_q.push_back('{chan: 2'(ch), cnt: 4'(cnt)});
    wait_grant(ch);
    req[ch] = 1'b0;
    if (cfg_mid) begin
      cfg_we = 1'b1;
      cfg_pattern = 8'h00;
      @(negedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ngr;
    int last_t;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    cfg_we = 1'b0;
    cfg_pattern = '0;
    stat_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_det_valid", 32'(det_valid), 32'd0);
    check("rst_det_chan", 32'(det_chan), 32'd0);
    check("rst_det_count", 32'(det_count), 32'd0);
    check("rst_stat", 32'(stat_data), 32'd0);
    rst_n = 1'b1;
    fork monitor(); join_none

    // Basic match with latency and hold checks
    write_pattern(8'hA5);
    @(negedge clk);
    req[0] = 1'b1;
    req_data[7:0] = 8'hA5;
    exp_q.push_back('{chan: 2'd0, cnt: 4'd1});
    wait_grant(0);
    req[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("lat_e7_det_valid", 32'(det_valid), 32'd0);
    @(negedge clk);
    check("lat_e8_det_valid", 32'(det_valid), 32'd1);
    check("lat_e8_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_e9_det_valid", 32'(det_valid), 32'd0);
    check("lat_e9_busy", 32'(busy), 32'd0);
    check("hold_det_count", 32'(det_count), 32'd1);

    // Per-channel history across byte boundaries
    write_pattern(8'h0F);
    send(1, 8'h00, 0, 1'b0);
    send(2, 8'hFF, 0, 1'b0);
    send(1, 8'hF0, 1, 1'b0);
    send(2, 8'h0F, 1, 1'b0);

    // Overlapping matches and statistics
    write_pattern(8'hFF);
    send(3, 8'hFF, 1, 1'b0);
    send(3, 8'hFF, 8, 1'b0);
    stat_sel = 2'd3;
    @(negedge clk);
`ifdef SEQ_ARB_STATS_EN
    check("stat_ch3", 32'(stat_data), 32'd9);
`else
    check("stat_ch3", 32'(stat_data), 32'd0);
`endif

    // cfg_we and req on the same IDLE edge: pattern first, grant deferred
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = 8'h3C;
    req[0] = 1'b1;
    req_data[7:0] = 8'h3C;
    exp_q.push_back('{chan: 2'd0, cnt: 4'd1});
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_defer_grant", 32'(grant), 32'd0);
    wait_grant(0);
    req[0] = 1'b0;
    wait_idle();
    // Pattern write during SHIFT must be ignored
    send(0, 8'h3C, 1, 1'b1);
    send(0, 8'h3C, 1, 1'b0);

    // Mid-byte reset aborts the byte and clears history
    write_pattern(8'hFF);
    send(0, 8'hFF, 1, 1'b0);
    @(negedge clk);
    req[0] = 1'b1;
    req_data[7:0] = 8'hFF;
    wait_grant(0);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_det_valid", 32'(det_valid), 32'd0);
    check("abort_det_count", 32'(det_count), 32'd0);
    check("abort_stat", 32'(stat_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    write_pattern(8'hFF);
    send(0, 8'hFF, 1, 1'b0);

    // Round-robin with all channels requesting continuously
    do_reset();
    @(negedge clk);
    req_data = 32'h0000_0000;
    req = 4'b1111;
    exp_q.push_back('{chan: 2'd0, cnt: 4'd1});
    exp_q.push_back('{chan: 2'd1, cnt: 4'd1});
    exp_q.push_back('{chan: 2'd2, cnt: 4'd1});
    exp_q.push_back('{chan: 2'd3, cnt: 4'd1});
    exp_q.push_back('{chan: 2'd0, cnt: 4'd8});
    ngr = 0;
    last_t = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (grant != 4'b0000) begin
        check("rr_grant", 32'(grant), 32'(4'b0001 << order[ngr]));
        if (ngr > 0) check("rr_spacing", 32'(cyc - last_t), 32'd10);
        last_t = cyc;
        ngr++;
        if (ngr == 5) begin
          req = 4'b0000;
          break;
        end
      end
    end
    req = 4'b0000;
    check("rr_grant_total", 32'(ngr), 32'd5);
    wait_idle();

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Round-robin scheduler that shares one bit-serial pattern-matching engine among NREQ byte-wide requesters. Each granted byte is serialized MSB-first through a PAT_W-bit sliding window against a programmable pattern. Per-channel window history is saved and restored, so matches that straddle byte boundaries on the same channel are detected. It sits in front of the serial detection path and replaces one hard-wired detector per source.

## Interface
- NREQ, 4, number of requesters (2..8); CHW = $clog2(NREQ)
- PAT_W, 8, pattern/window width in bits (2..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-channel request; held until granted
- req_data  in  8*NREQ  channel i byte at [8i+7:8i]; stable while req[i]=1
- grant  out  NREQ  one-hot, one-cycle pulse; byte sampled at that edge
- cfg_we  in  1  pattern write strobe
- cfg_pattern  in  PAT_W  new pattern
- busy  out  1  state != IDLE
- det_valid  out  1  one-cycle result strobe
- det_chan  out  CHW  channel of result
- det_count  out  4  matches within the byte (0..8)
- stat_sel  in  CHW  statistics channel select
- stat_data  out  16  statistics read data

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE with cfg_we=1: load pattern, clear all channel fill counters, stay IDLE. cfg_we has priority over req on the same edge, and the grant is deferred one cycle. cfg_we outside IDLE is ignored.
- IDLE with cfg_we=0 and |req:
  - Pick a channel round-robin, searching from last+1 cyclically; last resets to NREQ-1.
  - Register grant[i], latch byte, load window/fill of channel i, clear bit counter and det accumulator, go to SHIFT.
- SHIFT, one bit per edge, MSB first:
  - window = {window[PAT_W-2:0], bit}.
  - fill = min(fill+1, PAT_W).
  - If fill==PAT_W after the update and window==pattern, increment the accumulator.
  - After the 8th bit, write window/fill back to channel i, update last=i, go to REPORT.
- REPORT: det_valid=1, det_chan=i, det_count=accumulator; next edge to IDLE.
- Overlapping matches are counted; no window reset on a match.
- Fill gating: no match can be declared on reset/cleared history bits.
- Reset values: state IDLE, grant 0, det_valid 0, det_chan 0, det_count 0, busy 0, pattern 0, all windows/fill 0, last NREQ-1, stats 0.
- rst_n asserted mid-operation aborts the byte: no det_valid for it, all history lost.
- A req dropped before grant is simply not served. Any req change after grant is ignored for the in-flight byte.

## Timing
- Edge E0 (IDLE, req seen): grant high E0..E1.
- Shift edges E1..E8; REPORT E8..E9 (det_valid, det_chan, det_count valid together; det_count/det_chan hold until the next REPORT).
- Back in IDLE after E9; earliest next grant at E10. Throughput is one byte per 10 cycles.
- Worst-case wait for a continuously requesting channel: NREQ-1 other bytes (10*(NREQ-1) cycles).
- busy is registered: high from E0 to E9.

## Configuration
- SEQ_ARB_STATS_EN defined:
  - Per-channel 16-bit saturating counters add det_count at each REPORT.
  - stat_data = counter[stat_sel], combinational read.
  - Counters clear on rst_n only, not on cfg_we.
- Undefined: no counters; stat_data tied to 16'h0000; stat_sel unused.

## Test plan
- Reset, cfg_we pattern 8'hA5, ch0 sends 8'hA5: grant[0] at E0, det_valid at E8..E9, det_chan=0, det_count=1; busy low after E9.
- Pattern 8'h0F. ch1 sends 8'h00 (count 0), ch2 sends 8'hFF (count 0, fill<8), ch1 sends 8'hF0: ch1 count=1 via its restored history; ch2 unaffected.
- Pattern 8'hFF, ch3 sends 8'hFF then 8'hFF: counts 1 then 8 (overlap). With SEQ_ARB_STATS_EN, stat_sel=3 reads 9.
- req=4'b1111 held continuously after reset: grant order 0,1,2,3,0, grants 10 cycles apart.
- cfg_we and req[0] asserted on the same IDLE edge: pattern updated, grant[0] one cycle later. cfg_we during SHIFT: pattern unchanged and det_count reflects the old pattern.
- Pattern 8'hFF, ch0 sends 8'hFF, rst_n pulsed low at E4: all outputs 0, no det_valid. After release, rewrite pattern 8'hFF; ch0 8'hFF again yields det_count=1 (history cleared).
